// File: rtl/rf_wb_arbiter_if.sv
// ============================================================================
// Module   : rf_wb_arbiter_if
// Brief    : Writeback / LLU / decode / regfile-port bundle for rf_wb_arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rf_wb_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        llu_issue;
  logic [4:0]  llu_issue_rd;
  logic        llu_valid;
  logic [4:0]  llu_rd;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_stall;
  logic        pipe_hold;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] busy_mask;
  logic        proto_err;

  modport master (
    output wb_valid, wb_rd, wb_data,
    output llu_issue, llu_issue_rd, llu_valid, llu_rd, llu_data,
    output dec_rs1, dec_rs2, dec_rd,
    input  llu_ready, dec_stall, pipe_hold,
    input  rf_we, rf_wa, rf_wd, busy_mask, proto_err
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  llu_issue, llu_issue_rd, llu_valid, llu_rd, llu_data,
    input  dec_rs1, dec_rs2, dec_rd,
    output llu_ready, dec_stall, pipe_hold,
    output rf_we, rf_wa, rf_wd, busy_mask, proto_err
  );
endinterface

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module   : rf_wb_arbiter
// Brief    : Shares the regfile write port between WB and the LLU, tracks
//            LLU destinations in a busy scoreboard, holds the pipe on starvation
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  rf_wb_arbiter_if.slave bus
);

  localparam logic [0:0]       ST_ARB     = 1'b0;
  localparam logic [0:0]       ST_HOLD    = 1'b1;
  localparam logic [CNT_W-1:0] C_CNT_TRIP = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

  logic [0:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [31:0]      busy_q,      busy_d;
  logic             proto_err_q, proto_err_d;
  logic             rf_we_q,     rf_we_d;
  logic [4:0]       rf_wa_q,     rf_wa_d;
  logic [31:0]      rf_wd_q,     rf_wd_d;

  logic w_llu_ready;
  logic w_llu_hs;
  logic w_wb_grant;

  // In HOLD the LLU always wins; in ARB it only gets idle WB slots.
  assign w_llu_ready = !rst && ((state_q == ST_HOLD) || !bus.wb_valid);
  assign w_llu_hs    = bus.llu_valid && w_llu_ready;
  assign w_wb_grant  = (state_q == ST_ARB) && bus.wb_valid;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    proto_err_d = proto_err_q;
    rf_we_d     = 1'b0;
    rf_wa_d     = rf_wa_q;
    rf_wd_d     = rf_wd_q;

    if (w_wb_grant) begin
      if (bus.wb_rd != 5'd0) begin
        rf_we_d = 1'b1;
        rf_wa_d = bus.wb_rd;
        rf_wd_d = bus.wb_data;
      end
    end else if (w_llu_hs) begin
      if (bus.llu_rd != 5'd0) begin
        rf_we_d = 1'b1;
        rf_wa_d = bus.llu_rd;
        rf_wd_d = bus.llu_data;
      end
    end

    case (state_q)
      ST_ARB: begin
        if (bus.llu_valid && bus.wb_valid) begin
          if (cnt_q == C_CNT_TRIP) state_d = ST_HOLD;
          if (cnt_q != C_CNT_MAX)  cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (w_llu_hs) begin
          state_d = ST_ARB;
          cnt_d   = '0;
        end
        if (bus.wb_valid) proto_err_d = 1'b1;
      end
      default: state_d = ST_ARB;
    endcase

    // Clear before set so an issue landing on a completing rd keeps it busy.
    if (w_llu_hs && bus.llu_rd != 5'd0) begin
      if (!busy_q[bus.llu_rd]) proto_err_d = 1'b1;
      busy_d[bus.llu_rd] = 1'b0;
    end
    if (bus.llu_issue && bus.llu_issue_rd != 5'd0) begin
      if (busy_q[bus.llu_issue_rd]) proto_err_d = 1'b1;
      busy_d[bus.llu_issue_rd] = 1'b1;
    end
    if (bus.wb_valid && busy_q[bus.wb_rd]) proto_err_d = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      cnt_q       <= '0;
      busy_q      <= '0;
      proto_err_q <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      proto_err_q <= proto_err_d;
      rf_we_q     <= rf_we_d;
      rf_wa_q     <= rf_wa_d;
      rf_wd_q     <= rf_wd_d;
    end
  end

  assign bus.llu_ready = w_llu_ready;
  assign bus.dec_stall = !rst && (busy_q[bus.dec_rs1] || busy_q[bus.dec_rs2] ||
                                  busy_q[bus.dec_rd]);
  assign bus.pipe_hold = (state_q == ST_HOLD);
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_wa     = rf_wa_q;
  assign bus.rf_wd     = rf_wd_q;
  assign bus.busy_mask = busy_q;
  assign bus.proto_err = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Brief    : Directed self-checking bench for rf_wb_arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(.STARVE_LIMIT(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.llu_issue = 1'b0; bus.llu_issue_rd = '0;
    bus.llu_valid = 1'b0; bus.llu_rd = '0; bus.llu_data = '0;
    bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rd = '0;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.llu_issue = 1'b1; bus.llu_issue_rd = rd;
    step();
    bus.llu_issue = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    bus.llu_valid = 1'b1;
    #1 chk("ready_in_rst", {31'd0, bus.llu_ready}, 32'd0);
    step(); step();
    bus.llu_valid = 1'b0;
    rst = 1'b0;
    chk("rst_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rst_wa", {27'd0, bus.rf_wa}, 32'd0);
    chk("rst_wd", bus.rf_wd, 32'd0);
    chk("rst_busy", bus.busy_mask, 32'd0);
    chk("rst_hold", {31'd0, bus.pipe_hold}, 32'd0);
    chk("rst_perr", {31'd0, bus.proto_err}, 32'd0);

    // WB-only writes
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
    step();
    chk("wb_we", {31'd0, bus.rf_we}, 32'd1);
    chk("wb_wa", {27'd0, bus.rf_wa}, 32'd5);
    chk("wb_wd", bus.rf_wd, 32'hDEADBEEF);
    bus.wb_rd = 5'd0; bus.wb_data = 32'h00001234;
    step();
    bus.wb_valid = 1'b0;
    chk("wb_x0_we", {31'd0, bus.rf_we}, 32'd0);
    chk("wb_x0_wa", {27'd0, bus.rf_wa}, 32'd5);
    chk("wb_x0_wd", bus.rf_wd, 32'hDEADBEEF);

    // Scoreboard set, stall, clear
    issue(5'd7);
    chk("sb_busy", bus.busy_mask, 32'h00000080);
    bus.dec_rs1 = 5'd7;
    #1 chk("sb_stall", {31'd0, bus.dec_stall}, 32'd1);
    bus.dec_rs1 = 5'd0; bus.dec_rd = 5'd0;
    #1 chk("sb_nostall_x0", {31'd0, bus.dec_stall}, 32'd0);
    bus.llu_valid = 1'b1; bus.llu_rd = 5'd7; bus.llu_data = 32'h12;
    #1 chk("sb_ready", {31'd0, bus.llu_ready}, 32'd1);
    step();
    bus.llu_valid = 1'b0;
    chk("sb_we", {31'd0, bus.rf_we}, 32'd1);
    chk("sb_wa", {27'd0, bus.rf_wa}, 32'd7);
    chk("sb_wd", bus.rf_wd, 32'h12);
    chk("sb_clr", bus.busy_mask, 32'd0);
    bus.dec_rs1 = 5'd7;
    #1 chk("sb_stall_clr", {31'd0, bus.dec_stall}, 32'd0);
    bus.dec_rs1 = 5'd0;

    // One cycle of contention: WB first, LLU next
    issue(5'd4);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd10; bus.wb_data = 32'hAAAA0001;
    bus.llu_valid = 1'b1; bus.llu_rd = 5'd4; bus.llu_data = 32'hBBBB0002;
    #1 chk("ct_blocked", {31'd0, bus.llu_ready}, 32'd0);
    step();
    bus.wb_valid = 1'b0;
    chk("ct_wb_wa", {27'd0, bus.rf_wa}, 32'd10);
    chk("ct_wb_wd", bus.rf_wd, 32'hAAAA0001);
    chk("ct_hold0", {31'd0, bus.pipe_hold}, 32'd0);
    #1 chk("ct_ready", {31'd0, bus.llu_ready}, 32'd1);
    step();
    bus.llu_valid = 1'b0;
    chk("ct_llu_we", {31'd0, bus.rf_we}, 32'd1);
    chk("ct_llu_wa", {27'd0, bus.rf_wa}, 32'd4);
    chk("ct_llu_wd", bus.rf_wd, 32'hBBBB0002);
    chk("ct_hold1", {31'd0, bus.pipe_hold}, 32'd0);

    // Starvation hold after 8 blocked cycles
    issue(5'd6);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd11; bus.wb_data = 32'hCCCC0003;
    bus.llu_valid = 1'b1; bus.llu_rd = 5'd6; bus.llu_data = 32'hDDDD0004;
    repeat (7) step();
    chk("sv_hold_7", {31'd0, bus.pipe_hold}, 32'd0);
    step();
    chk("sv_hold_8", {31'd0, bus.pipe_hold}, 32'd1);
    chk("sv_wb_wa", {27'd0, bus.rf_wa}, 32'd11);
    bus.wb_valid = 1'b0;
    #1 chk("sv_ready", {31'd0, bus.llu_ready}, 32'd1);
    step();
    bus.llu_valid = 1'b0;
    chk("sv_llu_wa", {27'd0, bus.rf_wa}, 32'd6);
    chk("sv_llu_wd", bus.rf_wd, 32'hDDDD0004);
    chk("sv_hold_off", {31'd0, bus.pipe_hold}, 32'd0);
    chk("sv_perr", {31'd0, bus.proto_err}, 32'd0);
    chk("sv_busy", bus.busy_mask, 32'd0);

    // Same-rd completion and re-issue: set wins, re-issue to busy rd flags
    issue(5'd3);
    bus.llu_issue = 1'b1; bus.llu_issue_rd = 5'd3;
    bus.llu_valid = 1'b1; bus.llu_rd = 5'd3; bus.llu_data = 32'h33;
    step();
    bus.llu_issue = 1'b0; bus.llu_valid = 1'b0;
    chk("sr_busy", bus.busy_mask, 32'h00000008);
    chk("sr_wa", {27'd0, bus.rf_wa}, 32'd3);
    chk("sr_wd", bus.rf_wd, 32'h33);
    chk("sr_perr", {31'd0, bus.proto_err}, 32'd1);

    rst = 1'b1; step(); rst = 1'b0;
    chk("r2_perr", {31'd0, bus.proto_err}, 32'd0);
    chk("r2_busy", bus.busy_mask, 32'd0);

    // WB to a busy rd
    issue(5'd9);
    chk("waw_busy", bus.busy_mask, 32'h00000200);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h99;
    step();
    bus.wb_valid = 1'b0;
    chk("waw_perr", {31'd0, bus.proto_err}, 32'd1);
    chk("waw_wa", {27'd0, bus.rf_wa}, 32'd9);
    step(); step();
    chk("waw_sticky", {31'd0, bus.proto_err}, 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("r3_perr", {31'd0, bus.proto_err}, 32'd0);

    // WB presented during HOLD is dropped and flagged
    issue(5'd12);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd13; bus.wb_data = 32'h1313;
    bus.llu_valid = 1'b1; bus.llu_rd = 5'd12; bus.llu_data = 32'h1212;
    repeat (8) step();
    chk("hv_hold", {31'd0, bus.pipe_hold}, 32'd1);
    chk("hv_perr0", {31'd0, bus.proto_err}, 32'd0);
    bus.wb_rd = 5'd14; bus.wb_data = 32'h1414;
    step();
    bus.wb_valid = 1'b0; bus.llu_valid = 1'b0;
    chk("hv_perr1", {31'd0, bus.proto_err}, 32'd1);
    chk("hv_wa", {27'd0, bus.rf_wa}, 32'd12);
    chk("hv_wd", bus.rf_wd, 32'h1212);
    chk("hv_hold_off", {31'd0, bus.pipe_hold}, 32'd0);
    rst = 1'b1; step(); rst = 1'b0;

    // Reset in the middle of HOLD
    issue(5'd15);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd16; bus.wb_data = 32'h1616;
    bus.llu_valid = 1'b1; bus.llu_rd = 5'd15; bus.llu_data = 32'h1515;
    repeat (8) step();
    chk("rh_hold", {31'd0, bus.pipe_hold}, 32'd1);
    chk("rh_busy", bus.busy_mask, 32'h00008000);
    bus.wb_valid = 1'b0;
    rst = 1'b1;
    #1 chk("rh_ready_rst", {31'd0, bus.llu_ready}, 32'd0);
    step();
    rst = 1'b0;
    bus.llu_valid = 1'b0;
    chk("rh_hold_off", {31'd0, bus.pipe_hold}, 32'd0);
    chk("rh_busy_clr", bus.busy_mask, 32'd0);
    chk("rh_perr", {31'd0, bus.proto_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
